// File: rtl/mock_uart_pkg.sv
// rtl/mock_uart_pkg.sv - shared bus codes, register offsets and status layout for mock_uart
package mock_uart_pkg;

  // Bus access codes: load byte (read) and store byte (write).
  localparam logic [3:0] IO_LB = 4'h4;
  localparam logic [3:0] IO_SB = 4'hC;

  // Register offsets decoded from addr[3:0].
  localparam logic [3:0] REG_DATA = 4'h8;
  localparam logic [3:0] REG_STAT = 4'hC;

  typedef struct packed {
    logic [2:0] rsvd;
    logic       tx_idle;      // TX empty and gap counter drained
    logic       tx_drop;      // sticky: a write found TX full
    logic       rx_overflow;  // sticky: an RX byte found RX full
    logic       rx_nonempty;
    logic       tx_not_full;
  } status_t;

  // Gap counter width: enough for TX_GAP, never narrower than one bit.
  function automatic int gap_width(input int gap);
    return (gap > 0) ? $clog2(gap + 1) : 1;
  endfunction

endpackage

// File: rtl/mock_uart_if.sv
// rtl/mock_uart_if.sv - bus, RX stream and TX stream signals of mock_uart
// Ports (all carried as interface signals):
//   mode/addr/wdata/rdata      : byte register bus
//   rx_valid/rx_data           : external RX byte source
//   tx_valid/tx_data/tx_ready  : TX byte stream to a sink
interface mock_uart_if;
  logic [3:0]  mode;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  modport master (
    output mode, addr, wdata, rx_valid, rx_data, tx_ready,
    input  rdata, tx_valid, tx_data
  );

  modport slave (
    input  mode, addr, wdata, rx_valid, rx_data, tx_ready,
    output rdata, tx_valid, tx_data
  );
endinterface

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - generic byte FIFO with count-based full/empty
// Ports:
//   clk, rst_n      : clock, async active-low reset (empties the FIFO)
//   push_i, din_i   : write request and data; honoured when not full or when popping
//   pop_i           : read request; ignored when empty
//   full_o, empty_o : occupancy flags
//   head_o          : oldest entry (combinational)
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic [7:0] din_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output logic [7:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [7:0]    mem_q [DEPTH];
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW + 1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal when the same edge frees a slot.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
      2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is not reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/mock_uart.sv
// rtl/mock_uart.sv - register-mapped UART model with RX/TX byte FIFOs and TX inter-byte gap
// Ports:
//   clk, rst_n : clock, async active-low reset
//   bus        : mock_uart_if.slave (register bus, RX input stream, TX output stream)
// Registers: addr 0x8 data (read pops RX, write pushes TX), addr 0xC status / sticky clear.
module mock_uart
  import mock_uart_pkg::*;
#(
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 16,
  parameter int TX_GAP   = 4
) (
  input logic         clk,
  input logic         rst_n,
  mock_uart_if.slave  bus
);

  localparam int GW = gap_width(TX_GAP);

  logic is_read, is_write, is_stat, is_clr;
  logic rx_full, rx_empty, rx_pop, rx_push;
  logic tx_full, tx_empty, tx_pop, tx_push;
  logic [7:0] rx_head, tx_head;
  logic rx_ovf_q, rx_ovf_d;
  logic tx_drop_q, tx_drop_d;
  logic [GW-1:0] gap_q, gap_d;
  status_t status;
  logic unused_ok;

  assign is_read  = (bus.mode == IO_LB) && (bus.addr[3:0] == REG_DATA);
  assign is_write = (bus.mode == IO_SB) && (bus.addr[3:0] == REG_DATA);
  assign is_stat  = (bus.mode == IO_LB) && (bus.addr[3:0] == REG_STAT);
  assign is_clr   = (bus.mode == IO_SB) && (bus.addr[3:0] == REG_STAT);

  assign unused_ok = ^{bus.addr[31:4], bus.wdata[31:8]};

  // RX side: a read of an empty RX changes nothing.
  assign rx_pop  = is_read & ~rx_empty;
  assign rx_push = bus.rx_valid;

  // TX side: a byte leaves only once the gap after the previous one has elapsed.
  assign bus.tx_valid = ~tx_empty & (gap_q == '0);
  assign bus.tx_data  = tx_head;
  assign tx_pop       = bus.tx_valid & bus.tx_ready;
  assign tx_push      = is_write;

  byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rx_push),
    .din_i   (bus.rx_data),
    .pop_i   (rx_pop),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .head_o  (rx_head)
  );

  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (tx_push),
    .din_i   (bus.wdata[7:0]),
    .pop_i   (tx_pop),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .head_o  (tx_head)
  );

  always_comb begin
    status             = '0;
    status.tx_not_full = ~tx_full;
    status.rx_nonempty = ~rx_empty;
    status.rx_overflow = rx_ovf_q;
    status.tx_drop     = tx_drop_q;
    status.tx_idle     = tx_empty & (gap_q == '0);
  end

  always_comb begin
    bus.rdata = '0;
    if (rx_pop)       bus.rdata = {24'b0, rx_head};
    else if (is_stat) bus.rdata = {24'b0, status};
  end

  // Sticky flags: the set term is checked last so it beats a same-cycle clear.
  always_comb begin
    rx_ovf_d  = rx_ovf_q;
    tx_drop_d = tx_drop_q;
    if (is_clr && bus.wdata[2]) rx_ovf_d  = 1'b0;
    if (is_clr && bus.wdata[3]) tx_drop_d = 1'b0;
    if (bus.rx_valid && rx_full && !rx_pop) rx_ovf_d  = 1'b1;
    if (is_write && tx_full && !tx_pop)     tx_drop_d = 1'b1;
  end

  always_comb begin
    gap_d = gap_q;
    if (tx_pop)             gap_d = GW'(TX_GAP);
    else if (gap_q != '0)   gap_d = gap_q - GW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ovf_q  <= 1'b0;
      tx_drop_q <= 1'b0;
      gap_q     <= '0;
    end else begin
      rx_ovf_q  <= rx_ovf_d;
      tx_drop_q <= tx_drop_d;
      gap_q     <= gap_d;
    end
  end

endmodule

// File: tb/tb_mock_uart.sv
// tb/tb_mock_uart.sv - scoreboard bench for mock_uart
module tb_mock_uart;
  import mock_uart_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] rd_q [$];
  logic [7:0] tx_q [$];
  int         acc_q [$];
  logic       hold_q = 1'b0;
  logic [7:0] hold_data = 8'h00;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mock_uart_if u_if ();

  mock_uart #(.RX_DEPTH(16), .TX_DEPTH(16), .TX_GAP(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every bus read and every TX handshake against the queues.
  always @(negedge clk) begin
    if (u_if.mode == IO_LB && (u_if.addr[3:0] == REG_DATA || u_if.addr[3:0] == REG_STAT)) begin
      if (rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_unexpected: got 0x%0h expected no read", u_if.rdata);
      end else begin
        check("rdata", u_if.rdata, {24'h0, rd_q.pop_front()});
      end
    end
    if (u_if.tx_valid && u_if.tx_ready) begin
      acc_q.push_back(cyc);
      if (tx_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL tx_unexpected: got 0x%0h expected no byte", u_if.tx_data);
      end else begin
        check("tx_data", {24'h0, u_if.tx_data}, {24'h0, tx_q.pop_front()});
      end
    end
    if (hold_q && u_if.tx_valid) check("tx_stable", {24'h0, u_if.tx_data}, {24'h0, hold_data});
    hold_q    = u_if.tx_valid & ~u_if.tx_ready;
    hold_data = u_if.tx_data;
  end

  task automatic bus_op(input logic [3:0] m, input logic [3:0] a, input logic [7:0] d);
    u_if.mode  = m;
    u_if.addr  = {28'h0, a};
    u_if.wdata = {24'h0, d};
    @(posedge clk); #1;
    u_if.mode  = 4'h0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] exp);
    rd_q.push_back(exp);
    bus_op(IO_LB, a, 8'h00);
  endtask

  task automatic wr_tx(input logic [7:0] d, input logic expect_out);
    if (expect_out) tx_q.push_back(d);
    bus_op(IO_SB, REG_DATA, d);
  endtask

  task automatic rx_push(input logic [7:0] d);
    u_if.rx_valid = 1'b1;
    u_if.rx_data  = d;
    @(posedge clk); #1;
    u_if.rx_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (tx_q.size() != 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (tx_q.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d bytes left expected 0", name, tx_q.size());
    end
  endtask

  initial begin
    int wcyc;
    u_if.mode = 4'h0; u_if.addr = '0; u_if.wdata = '0;
    u_if.rx_valid = 1'b0; u_if.rx_data = '0; u_if.tx_ready = 1'b0;

    // Reset state, including status read while reset is held.
    repeat (2) @(posedge clk);
    #1;
    check("reset_tx_valid", {31'h0, u_if.tx_valid}, 32'h0);
    rd_q.push_back(8'h11);
    u_if.mode = IO_LB; u_if.addr = {28'h0, REG_STAT};
    @(posedge clk); #1;
    u_if.mode = 4'h0;
    rst_n = 1'b1;
    rd(REG_STAT, 8'h11);

    // Two RX bytes, then read past empty.
    rx_push(8'h47);
    rx_push(8'h52);
    rd(REG_DATA, 8'h47);
    rd(REG_DATA, 8'h52);
    rd(REG_DATA, 8'h00);
    rd(REG_STAT, 8'h11);

    // RX overflow: 17 pushes, 16 kept in order, then clear the sticky bit.
    for (int i = 0; i < 17; i++) rx_push(8'h10 + 8'(i));
    rd(REG_STAT, 8'h17);
    for (int i = 0; i < 16; i++) rd(REG_DATA, 8'h10 + 8'(i));
    rd(REG_STAT, 8'h15);
    bus_op(IO_SB, REG_STAT, 8'h04);
    rd(REG_STAT, 8'h11);

    // TX latency and inter-byte gap.
    u_if.tx_ready = 1'b1;
    acc_q.delete();
    wcyc = cyc;
    wr_tx(8'h41, 1'b1);
    wr_tx(8'h42, 1'b1);
    wait_drain("drain_gap");
    checks++;
    if (acc_q.size() < 2) begin
      errors++;
      $display("FAIL gap_count: got %0d accepts expected 2", acc_q.size());
    end else begin
      check("tx_latency", acc_q[0], wcyc + 1);
      check("tx_gap", acc_q[1] - acc_q[0], 5);
    end
    repeat (8) @(posedge clk);
    #1;
    rd(REG_STAT, 8'h11);

    // TX backpressure: fill, drop one, drain in order.
    u_if.tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) wr_tx(8'h60 + 8'(i), 1'b1);
    rd(REG_STAT, 8'h00);
    wr_tx(8'h70, 1'b0);
    rd(REG_STAT, 8'h08);
    u_if.tx_ready = 1'b1;
    wait_drain("drain_full");
    repeat (8) @(posedge clk);
    #1;
    rd(REG_STAT, 8'h19);
    bus_op(IO_SB, REG_STAT, 8'h08);
    rd(REG_STAT, 8'h11);

    // Reset with queued TX bytes: nothing may come out afterwards.
    u_if.tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) wr_tx(8'hA0 + 8'(i), 1'b0);
    check("tx_valid_before_rst", {31'h0, u_if.tx_valid}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_tx_valid", {31'h0, u_if.tx_valid}, 32'h0);
    rd_q.push_back(8'h11);
    u_if.mode = IO_LB; u_if.addr = {28'h0, REG_STAT};
    @(posedge clk); #1;
    u_if.mode = 4'h0;
    rst_n = 1'b1;
    u_if.tx_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    rd(REG_STAT, 8'h11);
    check("rd_queue_empty", rd_q.size(), 0);
    check("tx_queue_empty", tx_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mock_uart.md
MOCK_UART -- requirements
Module: mock_uart

Interface
REQ-001 Parameter RX_DEPTH, default 16: RX FIFO entries; power of two, at least 2.
REQ-002 Parameter TX_DEPTH, default 16: TX FIFO entries; power of two, at least 2.
REQ-003 Parameter TX_GAP, default 4: idle cycles enforced after each TX byte leaves; 0 means back-to-back.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 Port mode, input, 4: bus access type; uses the shared IO_LB and IO_SB codes; any other value means no access.
REQ-007 Port addr, input, 32: bus address; only addr[3:0] is decoded.
REQ-008 Port wdata, input, 32: bus write data; only wdata[7:0] is used.
REQ-009 Port rdata, output, 32: bus read data; combinational.
REQ-010 Port rx_valid, input, 1: an external RX byte is present this cycle.
REQ-011 Port rx_data, input, 8: the external RX byte.
REQ-012 Port tx_valid, output, 1: a TX byte is offered.
REQ-013 Port tx_data, output, 8: the offered TX byte.
REQ-014 Port tx_ready, input, 1: the sink accepts tx_data this cycle.

Function
REQ-015 Decode:
- is_read = mode==IO_LB and addr[3:0]==0x8
- is_write = mode==IO_SB and addr[3:0]==0x8
- is_stat = mode==IO_LB and addr[3:0]==0xC
- is_clr = mode==IO_SB and addr[3:0]==0xC
REQ-016 rdata SHALL be: {24'b0, RX head} on is_read with RX non-empty; {24'b0, status} on is_stat; 0 otherwise.
REQ-017 Status bits: bit0 = TX not full; bit1 = RX non-empty; bit2 = rx_overflow (sticky); bit3 = tx_drop (sticky); bit4 = TX empty and gap counter zero; bits7:5 = 0.
REQ-018 is_read with RX non-empty SHALL pop RX at the clock edge; is_read with RX empty SHALL return 0 and change no state.
REQ-019 rx_valid SHALL push rx_data when RX is not full, or when RX is full and the same cycle pops.
REQ-020 rx_valid with RX full and no pop SHALL drop the byte and set rx_overflow.
REQ-021 Simultaneous RX push and pop SHALL leave the RX count unchanged and preserve FIFO order.
REQ-022 is_write SHALL push wdata[7:0] into TX when TX is not full, or when TX is full and the same cycle pops.
REQ-023 Otherwise is_write SHALL drop the byte and set tx_drop.
REQ-024 is_clr SHALL clear rx_overflow when wdata[2]=1 and tx_drop when wdata[3]=1; it takes effect next cycle.
REQ-025 A set event in the same cycle as a clear SHALL win.
REQ-026 tx_valid = TX non-empty and gap counter == 0; tx_data = TX head.
REQ-027 tx_data SHALL stay stable while tx_valid=1 and tx_ready=0.
REQ-028 tx_valid and tx_ready together SHALL pop TX and load the gap counter with TX_GAP.
REQ-029 The gap counter SHALL decrement by 1 per cycle while non-zero and saturate at 0; its width is clog2(TX_GAP+1), minimum 1.
REQ-030 FIFO pointers SHALL be clog2(DEPTH) bits, wrap modulo DEPTH, and use an extra count bit to tell full from empty.
REQ-031 Minimum latency: bus write to tx_valid is 1 cycle; rx_valid to RX readable is 1 cycle.

Reset
REQ-032 rst_n low SHALL immediately empty both FIFOs and clear rx_overflow, tx_drop and the gap counter.
REQ-033 During reset: tx_valid=0; status reads 0x11; FIFO storage contents are don't-care.
REQ-034 Reset asserted mid-transfer SHALL discard all queued bytes with no partial output.

Structure
REQ-035 The IO_LB/IO_SB codes and the register offsets 0x8/0xC SHALL live in the shared defines header.
REQ-036 One generic sub-module, byte_fifo (parameter DEPTH; push, pop, full, empty, head), SHALL be instantiated for RX and for TX.
REQ-037 Target size: 150-250 lines of RTL in total.

Verification
REQ-038 Reset, then stat read -> 0x11; tx_valid=0.
REQ-039 rx_valid with bytes 0x47, 0x52, then three data reads -> 0x47, 0x52, then 0 with status bit1=0.
REQ-040 17 rx_valid pushes with RX_DEPTH=16 -> status bit2=1 and first 16 bytes read back in order; write 0x04 to 0xC -> bit2=0.
REQ-041 Write 0x41 and 0x42 with tx_ready=1 and TX_GAP=4 -> tx_valid at cycle+1 with 0x41, next 0x42 exactly 5 cycles later.
REQ-042 Hold tx_ready=0, write 17 bytes -> bit0=0 once full, bit3=1, tx_data constant; release -> 16 bytes drain in order.
REQ-043 Assert rst_n low while TX holds 5 bytes -> tx_valid=0 immediately; after release status = 0x11.
